// File: rtl/seq_sum_pkg.sv
// Shared types and sizing helpers for the serial multi-operand sum engine.
package seq_sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_NUM_OPS = 4;
  localparam int DEF_IDX_W   = $clog2(DEF_NUM_OPS);

  // Enough headroom that NUM_OPS maximal operands never wrap the accumulator.
  function automatic int acc_width(input int width, input int num_ops);
    return width + $clog2(num_ops);
  endfunction

  function automatic int idx_width(input int num_ops);
    return $clog2(num_ops);
  endfunction

endpackage

// File: rtl/sum_sat_trunc.sv
// Reduces the wide accumulator to a WIDTH-bit result with overflow flag and optional saturation.
module sum_sat_trunc
  import seq_sum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] acc,
  input  logic             sat_en,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  // Any set bit above the result width means the sum exceeded 2^WIDTH-1.
  assign ovf = |acc[ACC_W-1:WIDTH];
  assign sum = (sat_en && ovf) ? {WIDTH{1'b1}} : acc[WIDTH-1:0];

endmodule

// File: rtl/seq_sum_engine.sv
// Serial NUM_OPS-operand adder with start/busy/done handshake, overflow flag and optional saturation.
module seq_sum_engine
  import seq_sum_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sat_en,
  input  logic [NUM_OPS*WIDTH-1:0] ops_in,
  input  logic                     clear,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         sum,
  output logic                     ovf
);

  localparam int ACC_W = acc_width(WIDTH, NUM_OPS);
  localparam int IDX_W = idx_width(NUM_OPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  state_t                     state;
  logic [ACC_W-1:0]           acc;
  logic [ACC_W-1:0]           acc_next;
  logic [IDX_W-1:0]           idx;
  logic [NUM_OPS*WIDTH-1:0]   ops_q;
  logic                       sat_q;
  logic [WIDTH-1:0]           op_cur;
  logic [WIDTH-1:0]           sum_d;
  logic                       ovf_d;

  assign op_cur   = ops_q[int'(idx)*WIDTH +: WIDTH];
  assign acc_next = acc + ACC_W'(op_cur);

  // The result stage sees the accumulator including the final operand.
  sum_sat_trunc #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_sum_sat_trunc (
    .acc    (acc_next),
    .sat_en (sat_q),
    .sum    (sum_d),
    .ovf    (ovf_d)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: the captured operand register is reset like any other flop so a
  // post-reset job can never observe stale operands; it is small, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
      ops_q <= '0;
      sat_q <= 1'b0;
      sum   <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      // Abort keeps the last published result visible.
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ops_q <= ops_in;
            sat_q <= sat_en;
            acc   <= '0;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            sum   <= sum_d;
            ovf   <= ovf_d;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sum_engine.sv
// Scoreboard bench for seq_sum_engine: driver pushes expected results, monitor pops on done.
module tb_seq_sum_engine;

  localparam int WIDTH   = 8;
  localparam int NUM_OPS = 4;
  localparam int OPS_W   = NUM_OPS * WIDTH;
  localparam int MAXV    = (1 << WIDTH) - 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sat_en;
  logic [OPS_W-1:0] ops_in;
  logic             clear;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  seq_sum_engine #(
    .WIDTH   (WIDTH),
    .NUM_OPS (NUM_OPS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sat_en (sat_en),
    .ops_in (ops_in),
    .clear  (clear),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer sum of the operands, then the published result rules.
  function automatic exp_t model(input logic [OPS_W-1:0] ops, input logic sat);
    int   total = 0;
    exp_t e;
    for (int k = 0; k < NUM_OPS; k++) total += int'(ops[k*WIDTH +: WIDTH]);
    e.ovf = (total > MAXV);
    e.sum = (sat && e.ovf) ? WIDTH'(MAXV) : WIDTH'(total % (MAXV + 1));
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          check("result_sum", sum, e.sum);
          check("result_ovf", ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Drives one job starting at the next edge; checks busy/done timing each cycle.
  // interfere: re-pulses start with fresh ops/sat_en while the job is in flight.
  task automatic run_job(input logic [OPS_W-1:0] ops, input logic sat, input bit interfere);
    ops_in = ops;
    sat_en = sat;
    start  = 1'b1;
    exp_q.push_back(model(ops, sat));
    for (int c = 1; c <= NUM_OPS + 1; c++) begin
      @(negedge clk);
      check("busy_in_job", busy, 1);
      check("done_timing", done, (c == NUM_OPS + 1) ? 1 : 0);
      if (interfere) begin
        start  = 1'b1;
        ops_in = OPS_W'($urandom);
        sat_en = ~sat;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    logic [OPS_W-1:0] ops;
    rst_n  = 1'b0;
    start  = 1'b0;
    sat_en = 1'b0;
    ops_in = '0;
    clear  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job({8'd0, 8'd0, 8'd18, 8'd14}, 1'b0, 1'b0);
    check("hold_sum_32", sum, 32);
    run_job({8'd0, 8'd0, 8'd100, 8'd200}, 1'b0, 1'b0);
    run_job({8'd0, 8'd0, 8'd100, 8'd200}, 1'b1, 1'b0);
    run_job({4{8'd255}}, 1'b0, 1'b0);
    run_job({4{8'd255}}, 1'b1, 1'b0);

    // Job A with start/ops/sat churn while busy, then back-to-back job in the IDLE gap.
    run_job({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 1'b1);
    run_job({8'd0, 8'd0, 8'd18, 8'd14}, 1'b0, 1'b0);
    check("b2b_sum", sum, 32);

    // Abort with clear during ACCUM: no done, previous result stays.
    ops_in = {4{8'd255}};
    sat_en = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_to_idle", busy, 0);
    repeat (6) @(negedge clk);
    check("clear_keeps_sum", sum, 32);
    check("clear_keeps_ovf", ovf, 0);

    // clear wins over start in IDLE.
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    check("clear_beats_start", busy, 0);
    repeat (6) @(negedge clk);
    check("clear_beats_start_later", busy, 0);

    // Asynchronous reset mid-job.
    ops_in = {8'd9, 8'd9, 8'd9, 8'd9};
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_idle", busy, 0);

    // Randomised jobs, some saturated, some at full scale, some with interference.
    for (int j = 0; j < 24; j++) begin
      ops = OPS_W'($urandom);
      if ($urandom_range(0, 4) == 0) ops = '1;
      run_job(ops, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_sum_engine.md
Name: seq_sum_engine

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit two-operand sum task.
- Accepts NUM_OPS operands of WIDTH bits on a start pulse and accumulates them serially, one operand per clock.
- Returns the sum with an overflow flag and optional saturation, using a start/busy/done handshake.
- Sits between a register-bank front end and any consumer needing a reduced sum.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- NUM_OPS, 4, number of operands per job (>=2).
- ACC_W, WIDTH+$clog2(NUM_OPS), internal accumulator width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  job request; sampled only in IDLE.
- sat_en  input  1  1 = saturate result to 2^WIDTH-1; 0 = wrap; captured with start.
- ops_in  input  NUM_OPS*WIDTH  operand k in bits [k*WIDTH +: WIDTH]; captured with start.
- clear  input  1  synchronous abort; returns to IDLE, no done.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when result is valid.
- sum  output  WIDTH  registered result; held until next done.
- ovf  output  1  registered: full-precision sum exceeded 2^WIDTH-1; held with sum.

Behaviour:
- Reset (rst_n=0, any time, including mid-job): state=IDLE, busy=0, done=0, sum=0, ovf=0, acc=0, idx=0, captured operands=0.
- States:
  - IDLE: start=1 at edge T captures ops_in and sat_en, sets acc=0 and idx=0, and moves to ACCUM. Otherwise stays.
  - ACCUM: each edge does acc <= acc + op[idx] (zero-extended to ACC_W) and idx++. After adding op[NUM_OPS-1], moves to DONE.
  - DONE: lasts exactly one cycle with done=1, then returns to IDLE.
- Latency: ACCUM occupies cycles T+1..T+NUM_OPS. DONE (done=1) is cycle T+NUM_OPS+1. busy is high T+1..T+NUM_OPS+1.
- Result registration: sum and ovf update at the edge entering DONE, computed from the final acc.
  - ovf = (acc > 2^WIDTH-1).
  - sum = sat_en ? (ovf ? 2^WIDTH-1 : acc[WIDTH-1:0]) : acc[WIDTH-1:0].
- ACC_W guarantees the accumulator never wraps internally. All-max operands give NUM_OPS*(2^WIDTH-1) exactly.
- start while busy (ACCUM or DONE): ignored. No queuing, no effect on the captured operands.
- start in the IDLE cycle immediately after DONE: accepted, so back-to-back jobs run with a one-cycle gap.
- clear=1 in any state: next state IDLE, acc/idx=0, done stays 0, sum/ovf keep their previous values.
- clear and start asserted together in IDLE: clear wins, job not started.
- ops_in and sat_en changes after capture have no effect on the running job.
- done is never asserted outside DONE. busy and done are both driven from registered state.

Decomposition:
- Package seq_sum_pkg:
  - state enum {IDLE, ACCUM, DONE} (2-bit encoding).
  - function acc_width(WIDTH, NUM_OPS).
  - localparam for idx width $clog2(NUM_OPS).
- One combinational sub-module, sum_sat_trunc: parameters WIDTH and ACC_W; inputs acc and sat_en; outputs sum and ovf. Instantiated at the DONE-entry register stage.
- FSM, operand capture and accumulator stay in the top module.

Test Plan:
- WIDTH=8, NUM_OPS=4, ops={14,18,0,0}, sat_en=0, start at T -> busy T+1..T+5, done only at T+5, sum=32, ovf=0.
- ops={200,100,0,0}, sat_en=0 -> sum=44, ovf=1. Same ops with sat_en=1 -> sum=255, ovf=1.
- ops={255,255,255,255}, sat_en=0 -> sum=252 (1020 mod 256), ovf=1. No internal wrap: sat_en=1 gives 255.
- Start job A, pulse start with different ops and change ops_in during ACCUM -> result equals job A only. Second start in IDLE after done -> second job runs and its done lands 5 cycles later.
- Drop rst_n asynchronously at T+2 of a job -> busy, done, sum, ovf go to 0 immediately. After release, no done until a new start.
- Finish one job (sum=32), start another, assert clear at T+3 -> IDLE next cycle, no done pulse, sum stays 32, ovf stays 0. clear+start together in IDLE -> busy stays 0.
